// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: one PHY, one command in flight.
// The frame is sent MSB first from a 64-bit shift register, and one MDC
// period is used per bit. Read data is captured at the end of each data bit's
// high phase.
module mdio_master #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe
);

    // One frame bit lasts a full MDC period: D cycles low, then D cycles high.
    localparam int unsigned BIT_CYC = 2 * CLK_DIV;
    localparam logic [8:0]  DIV_LAST = 9'(BIT_CYC - 1);
    localparam logic [8:0]  DIV_HIGH = 9'(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic [63:0] sr_q, sr_d;
    logic        write_q, write_d;
    logic [15:0] rdata_q, rdata_d;

    logic in_frame;
    logic bit_end;

    assign in_frame = (state_q == S_PREAMBLE) || (state_q == S_HEADER) ||
                      (state_q == S_TA)       || (state_q == S_DATA);
    assign bit_end  = (div_q == DIV_LAST);

    // Next-state: latch the command, step the divider and bit counters, shift out the frame.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        write_d = write_q;
        rdata_d = rdata_q;

        if (in_frame) begin
            div_d = bit_end ? 9'd0 : div_q + 9'd1;
            if (bit_end) begin
                bit_d = bit_q + 6'd1;
                sr_d  = {sr_q[62:0], 1'b1};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = S_PREAMBLE;
                    div_d   = 9'd0;
                    bit_d   = 6'd0;
                    write_d = cmd_write;
                    rdata_d = 16'h0000;
                    // Reads keep ones in the TA/data slots so the released line idles high.
                    sr_d    = cmd_write ?
                        {32'hFFFF_FFFF, 2'b01, 2'b01, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata} :
                        {32'hFFFF_FFFF, 2'b01, 2'b10, cmd_phy_addr, cmd_reg_addr, 18'h3FFFF};
                end
            end
            S_PREAMBLE: if (bit_end && bit_q == 6'd31) state_d = S_HEADER;
            S_HEADER:   if (bit_end && bit_q == 6'd45) state_d = S_TA;
            S_TA:       if (bit_end && bit_q == 6'd47) state_d = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    rdata_d = {rdata_q[14:0], mdio_i};
                    if (bit_q == 6'd63) state_d = S_DONE;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= 9'd0;
            bit_q   <= 6'd0;
            sr_q    <= '1;
            write_q <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode from registered state, so MDIO only moves at bit starts.
    always_comb begin
        cmd_ready = (state_q == S_IDLE) && !rst;
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_DONE);
        rsp_rdata = (state_q == S_DONE && !write_q) ? rdata_q : 16'h0000;
        mdc       = in_frame && (div_q >= DIV_HIGH);
        mdio_oe   = (state_q == S_PREAMBLE) || (state_q == S_HEADER) ||
                    (((state_q == S_TA) || (state_q == S_DATA)) && write_q);
        mdio_o    = mdio_oe ? sr_q[63] : 1'b1;
    end

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: expectations are queued on acceptance and
// checked by a monitor on rsp_valid. Two instances cover CLK_DIV=10 and 2.
module tb_mdio_master;

    typedef struct {
        logic [15:0] rdata;
        logic [63:0] fo;
        logic [63:0] foe;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_write = 1'b0;
    logic [4:0] cmd_phy = 5'd0;
    logic [4:0] cmd_reg = 5'd0;
    logic [15:0] cmd_wdata = 16'h0;
    logic mdio_i = 1'b1;
    logic [15:0] phy_data = 16'h0;

    logic cv10, cr10, rv10, busy10, mdc10, mo10, moe10;
    logic cv2, cr2, rv2, busy2, mdc2, mo2, moe2;
    logic [15:0] rd10, rd2;
    logic cmd_ready_m, rsp_valid_m, busy_m, mdc_m, mdio_o_m, mdio_oe_m;
    logic [15:0] rsp_rdata_m;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_rsp_cyc = -1;
    int viol = 0;
    int rise = 0;
    logic [63:0] cap_o = '0;
    logic [63:0] cap_oe = '0;
    exp_t q[$];
    exp_t me;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cv10 = cmd_valid && !sel;
    assign cv2  = cmd_valid && sel;

    mdio_master #(.CLK_DIV(10)) dut10 (
        .clk(clk), .rst(rst), .cmd_valid(cv10), .cmd_ready(cr10),
        .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg),
        .cmd_wdata(cmd_wdata), .rsp_valid(rv10), .rsp_rdata(rd10), .busy(busy10),
        .mdc(mdc10), .mdio_i(mdio_i), .mdio_o(mo10), .mdio_oe(moe10));

    mdio_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cv2), .cmd_ready(cr2),
        .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg),
        .cmd_wdata(cmd_wdata), .rsp_valid(rv2), .rsp_rdata(rd2), .busy(busy2),
        .mdc(mdc2), .mdio_i(mdio_i), .mdio_o(mo2), .mdio_oe(moe2));

    assign cmd_ready_m = sel ? cr2   : cr10;
    assign rsp_valid_m = sel ? rv2   : rv10;
    assign rsp_rdata_m = sel ? rd2   : rd10;
    assign busy_m      = sel ? busy2 : busy10;
    assign mdc_m       = sel ? mdc2  : mdc10;
    assign mdio_o_m    = sel ? mo2   : mo10;
    assign mdio_oe_m   = sel ? moe2  : moe10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // PHY side: record what is on the wire at each MDC rise.
    always @(posedge mdc_m or negedge busy_m) begin
        if (!busy_m) begin
            rise   = 0;
            cap_o  = '0;
            cap_oe = '0;
        end else begin
            cap_o  = {cap_o[62:0], mdio_o_m};
            cap_oe = {cap_oe[62:0], mdio_oe_m};
            rise   = rise + 1;
        end
    end

    // PHY side: drive read turnaround and data during each bit's low phase.
    always @(negedge mdc_m) begin
        if (rise == 47)
            mdio_i = 1'b0;
        else if (rise >= 48 && rise <= 63)
            mdio_i = phy_data[63 - rise];
        else
            mdio_i = 1'b1;
    end

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (busy_m && cmd_ready_m) viol++;
        if (rsp_valid_m) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid_m), 64'd0);
            end else begin
                me = q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata_m), 64'(me.rdata));
                check("rsp_latency", 64'(cyc - me.acc), 64'(me.lat));
                check("frame_mdio_o", cap_o, me.fo);
                check("frame_mdio_oe", cap_oe, me.foe);
                check("mdc_rises", 64'(rise), 64'd64);
            end
            last_rsp_cyc = cyc;
        end
    end

    task automatic issue(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, output int acc);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_phy   = pa;
        cmd_reg   = ra;
        cmd_wdata = wd;
        acc = -1;
        for (int k = 0; k < 5000; k++) begin
            if (cmd_ready_m) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            fail_now("accept_timeout");
        end else begin
            e.rdata = w ? 16'h0000 : phy_data;
            e.fo    = w ? {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd}
                        : {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 18'h3FFFF};
            e.foe   = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFC_0000;
            e.lat   = sel ? 257 : 1281;
            e.acc   = acc;
            q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 3000 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int a1, a2;

        // Reset held 3 cycles: idle outputs, no ready.
        repeat (3) begin
            @(negedge clk);
            check("reset_idle", 64'({cmd_ready_m, rsp_valid_m, mdc_m, mdio_o_m, mdio_oe_m, busy_m, rsp_rdata_m}),
                  64'({6'b000100, 16'h0000}));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(cmd_ready_m), 64'd1);

        // Write, CLK_DIV=10.
        issue(1'b1, 5'h10, 5'h00, 16'h1140, a1);
        cmd_valid = 1'b0;
        drain();

        // Read, CLK_DIV=10.
        phy_data = 16'hBEEF;
        issue(1'b0, 5'h01, 5'h02, 16'h0000, a1);
        cmd_valid = 1'b0;
        drain();

        // Back-to-back: fields change mid-frame; second acceptance right after DONE.
        phy_data = 16'h1234;
        issue(1'b1, 5'h03, 5'h04, 16'hA5C3, a1);
        issue(1'b0, 5'h1F, 5'h1F, 16'hFFFF, a2);
        cmd_valid = 1'b0;
        check("b2b_second_accept", 64'(a2), 64'(last_rsp_cyc + 1));
        drain();

        // Reset in bit 40 of a read.
        phy_data = 16'h5A5A;
        issue(1'b0, 5'h07, 5'h09, 16'h0000, a1);
        cmd_valid = 1'b0;
        repeat (802) @(negedge clk);
        check("abort_at_bit40", 64'(rise), 64'd40);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", 64'({mdc_m, mdio_oe_m, busy_m, rsp_valid_m, mdio_o_m}), 64'(5'b00001));
        repeat (1400) @(negedge clk);
        issue(1'b1, 5'h05, 5'h1A, 16'h0001, a1);
        cmd_valid = 1'b0;
        drain();

        // CLK_DIV=2 instance: read with MSB and LSB set, then a write.
        sel = 1'b1;
        @(negedge clk);
        phy_data = 16'h8001;
        issue(1'b0, 5'h00, 5'h01, 16'h0000, a1);
        cmd_valid = 1'b0;
        drain();
        issue(1'b1, 5'h12, 5'h0D, 16'hFFFF, a1);
        cmd_valid = 1'b0;
        drain();

        check("ready_during_busy", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
